// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } pipe_state_t;

  localparam int PIPE_REG_IDX_W = 4;

  // Enable vector bit order, MSB first: {pc, if_id, id_ex, ex_mem, mem_wb}
  localparam int EN_W      = 5;
  localparam int EN_PC     = 4;
  localparam int EN_IF_ID  = 3;
  localparam int EN_ID_EX  = 2;
  localparam int EN_EX_MEM = 1;
  localparam int EN_MEM_WB = 0;

  localparam logic [EN_W-1:0] EN_ALL    = 5'b11111;
  localparam logic [EN_W-1:0] EN_NONE   = 5'b00000;
  localparam logic [EN_W-1:0] EN_FROZEN = 5'b00001;
  localparam logic [EN_W-1:0] EN_LDUSE  = 5'b00111;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// rtl/pipeline_controller_hazard_detect.sv - combinational load-use compare of ID sources against the EX load destination
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = PIPE_REG_IDX_W
) (
  input  logic [REG_IDX_W-1:0] id_Ra,
  input  logic [REG_IDX_W-1:0] id_Rb,
  input  logic [REG_IDX_W-1:0] id_Rc,
  input  logic                 id_useRa,
  input  logic                 id_useRb,
  input  logic                 id_useRc,
  input  logic [REG_IDX_W-1:0] ex_Rc,
  input  logic                 ex_memToReg,
  input  logic                 ex_regWrite,
  output logic                 load_use
);

  logic hit_a;
  logic hit_b;
  logic hit_c;

  always_comb begin
    hit_a    = id_useRa && (id_Ra == ex_Rc);
    hit_b    = id_useRb && (id_Rb == ex_Rc);
    hit_c    = id_useRc && (id_Rc == ex_Rc);
    load_use = ex_memToReg && ex_regWrite && (hit_a || hit_b || hit_c);
  end

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush sequencer for the 5-stage pipeline with memory-wait watchdog
// Optional perf counters (stall_cycles, flush_events) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W   = PIPE_REG_IDX_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_Ra,
  input  logic [REG_IDX_W-1:0] id_Rb,
  input  logic [REG_IDX_W-1:0] id_Rc,
  input  logic                 id_useRa,
  input  logic                 id_useRb,
  input  logic                 id_useRc,
  input  logic [REG_IDX_W-1:0] ex_Rc,
  input  logic                 ex_memToReg,
  input  logic                 ex_regWrite,
  input  logic                 ex_branchTaken,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  input  logic                 wb_halt,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
  output logic                 halted,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events,
`endif
  output logic                 mem_err
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(MEM_TIMEOUT);
  localparam logic [TO_CNT_W-1:0] CNT_MAX  = '1;

  pipe_state_t         state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [EN_W-1:0] en;
  logic            fl_if_id;
  logic            fl_id_ex;
  logic            fl_mem_wb;
  logic            service;
  logic            load_use;

  hazard_detect #(
    .REG_IDX_W (REG_IDX_W)
  ) u_hazard_detect (
    .id_Ra       (id_Ra),
    .id_Rb       (id_Rb),
    .id_Rc       (id_Rc),
    .id_useRa    (id_useRa),
    .id_useRb    (id_useRb),
    .id_useRc    (id_useRc),
    .ex_Rc       (ex_Rc),
    .ex_memToReg (ex_memToReg),
    .ex_regWrite (ex_regWrite),
    .load_use    (load_use)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    en        = EN_ALL;
    fl_if_id  = 1'b0;
    fl_id_ex  = 1'b0;
    fl_mem_wb = 1'b0;
    service   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (wb_halt) begin
          state_d = HALTED;
        end else if (mem_req && !mem_ack) begin
          en        = EN_FROZEN;
          fl_mem_wb = 1'b1;
          cnt_d     = TO_CNT_W'(1);
          state_d   = MEM_WAIT;
        end else begin
          service = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          service = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          en        = EN_FROZEN;
          fl_mem_wb = 1'b1;
          if (cnt_q == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = HALTED;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
          end
        end
      end
      default: begin
        en = EN_NONE;
      end
    endcase

    // Branch squash outranks load-use: the dependent instruction is being flushed anyway.
    if (service) begin
      if (ex_branchTaken) begin
        fl_if_id = 1'b1;
        fl_id_ex = 1'b1;
      end else if (load_use) begin
        en       = EN_LDUSE;
        fl_id_ex = 1'b1;
      end
    end

    if (!rst) begin
      en        = EN_NONE;
      fl_if_id  = 1'b0;
      fl_id_ex  = 1'b0;
      fl_mem_wb = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pc_en        = en[EN_PC];
  assign if_id_en     = en[EN_IF_ID];
  assign id_ex_en     = en[EN_ID_EX];
  assign ex_mem_en    = en[EN_EX_MEM];
  assign mem_wb_en    = en[EN_MEM_WB];
  assign if_id_flush  = fl_if_id;
  assign id_ex_flush  = fl_id_ex;
  assign mem_wb_flush = fl_mem_wb;
  assign halted       = rst && (state_q == HALTED);
  assign mem_err      = err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!en[EN_PC] && (state_q != HALTED)) stall_d = stall_q + 32'd1;
    if (fl_if_id || fl_id_ex)              flush_d = flush_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central stall/flush sequencer for the 5-stage 24-bit pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Resolves load-use hazards against the decode-stage register fields.
- Handles taken-branch squashing from EX.
- Freezes the pipeline during multi-cycle data-memory handshakes; watchdog-halts on a stuck memory.

Parameters:
REG_IDX_W, 4, register index width (Ra/Rb/Rc)
MEM_TIMEOUT, 64, max MEM_WAIT cycles before error halt (>=2)
TO_CNT_W, 8, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
id_Ra  in  REG_IDX_W  source A index of instruction in ID
id_Rb  in  REG_IDX_W  source B index in ID
id_Rc  in  REG_IDX_W  Rc index in ID (store-data source)
id_useRa / id_useRb / id_useRc  in  1 each  field is actually read by ID instruction
ex_Rc  in  REG_IDX_W  destination of instruction in EX
ex_memToReg  in  1  EX instruction is a load
ex_regWrite  in  1  EX instruction writes Rc
ex_branchTaken  in  1  branch in EX resolved taken
mem_req  in  1  MEM-stage instruction accesses data memory (level)
mem_ack  in  1  data memory completes access this cycle
wb_halt  in  1  halt instruction reached WB
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register/buffer enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  active-high one-cycle bubble insert into that buffer
halted  out  1  pipeline stopped (halt or error)
mem_err  out  1  sticky watchdog timeout flag

Behaviour:
- States: RUN, MEM_WAIT, HALTED. rst low -> RUN, timeout counter 0, mem_err 0, immediately and asynchronously.
- Outputs are combinational from state + inputs; the only flops are state, counter and mem_err.
- During reset: all enables 0, all flushes 0, halted 0.
- load_use = ex_memToReg & ex_regWrite & ((id_useRa & id_Ra==ex_Rc) | (id_useRb & id_Rb==ex_Rc) | (id_useRc & id_Rc==ex_Rc)).
- RUN, priority order (first match wins):
  1. wb_halt -> HALTED next cycle; this cycle: all enables 1, no flush (halt retires).
  2. mem_req & !mem_ack -> MEM_WAIT next cycle; this cycle: pc/if_id/id_ex/ex_mem enables 0, mem_wb_en 1, mem_wb_flush 1; counter loads 1.
  3. ex_branchTaken -> all enables 1, if_id_flush 1, id_ex_flush 1; load_use ignored.
  4. load_use -> pc_en 0, if_id_en 0, id_ex_flush 1, remaining enables 1; exactly one bubble, because the load leaves EX next cycle.
  5. Otherwise -> all enables 1, flushes 0.
- mem_req & mem_ack in the same RUN cycle: zero-wait access; fall through to rules 3-5.
- MEM_WAIT:
  - No ack: everything frozen as in RUN rule 2; counter increments.
  - mem_ack: RUN rules 3-5 apply this cycle (branch/load-use held in frozen stages are serviced now); next state RUN; counter cleared.
  - Counter == MEM_TIMEOUT and no ack: mem_err set; -> HALTED.
  - wb_halt is impossible here (MEM/WB receives bubbles); it is ignored.
- HALTED: all enables 0, flushes 0, halted 1. Exit only via rst; mem_err holds.
- Counter saturates and never wraps. Branch during mem stall is not lost: EX is frozen, so the input is held.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both cleared by rst.
  - stall_cycles increments on every cycle with pc_en 0 while not HALTED.
  - flush_events increments once per cycle with if_id_flush or id_ex_flush.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum pipe_state_t {RUN, MEM_WAIT, HALTED}
  - REG_IDX_W default
  - localparam for the enable-vector bit order {pc, if_id, id_ex, ex_mem, mem_wb}
- Sub-module hazard_detect: pure combinational load_use compare. This keeps the compare separately unit-testable.

Test Plan:
- Reset: hold rst=0 with random inputs -> all enables 0, halted 0, mem_err 0; release -> next cycle all enables 1.
- Load-use: ex_memToReg=1, ex_regWrite=1, ex_Rc=5, id_Ra=5, id_useRa=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Same with id_useRa=0 -> no stall.
- Branch beats load-use: ex_branchTaken=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_en=1.
- Memory wait: mem_req=1, ack after 3 cycles -> 3 frozen cycles with mem_wb_flush=1; on the ack cycle all enables 1; state back to RUN.
- Timeout: mem_req=1, mem_ack never asserted, MEM_TIMEOUT=4 -> mem_err=1 and halted=1 after 4 MEM_WAIT cycles; stays until rst=0.
- Halt: wb_halt=1 in RUN -> enables 1 that cycle, then halted=1 and all enables 0 indefinitely.
